// File: rtl/toggle_handshake_receiver.sv
// Receive end of a two-phase toggle CDC handshake: synchronises req_tgl, captures data_in, offers it on valid/ready, returns ack_tgl.
// Latency: req flip sampled at E0 -> out_valid at E0+SYNC_STAGES; backpressure holds the word, and a new request while full sets sticky overrun.
module toggle_handshake_receiver #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_tgl,
  input  logic [WIDTH-1:0] data_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             ack_tgl,
  output logic             overrun,
  output logic [CNT_W-1:0] xfer_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_req_seen;
  logic [WIDTH-1:0]       r_data;
  logic                   r_ack;
  logic                   r_ovr;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_event;
  logic                   w_take;
  logic                   w_load;
  logic                   w_ovr_set;

  // Only r_sync[0] may go metastable; every later stage is a clean copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync     <= '0;
      r_req_seen <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], req_tgl};
      r_req_seen <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_event = r_sync[SYNC_STAGES-1] ^ r_req_seen;
  assign w_take  = (r_state == HOLD) && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_event) begin
          w_load      = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // A same-edge take frees the register, so the new word is accepted.
        if (w_take && w_event) begin
          w_load = 1'b1;
        end else if (w_take) begin
          w_state_nxt = IDLE;
        end else if (w_event) begin
          w_ovr_set = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_ovr   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_data <= data_in;
      end
      if (w_take) begin
        r_ack <= ~r_ack;
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign out_valid  = (r_state == HOLD);
  assign data_out   = r_data;
  assign ack_tgl    = r_ack;
  assign overrun    = r_ovr;
  assign xfer_count = r_cnt;

endmodule

// File: tb/tb_toggle_handshake_receiver.sv
// Bench for toggle_handshake_receiver: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_toggle_handshake_receiver;

  localparam int SYNC = 2;

  logic       clk;
  logic       reset;
  logic       req_tgl;
  logic [7:0] data_in;
  logic       out_ready;

  logic       out_valid;
  logic [7:0] data_out;
  logic       ack_tgl;
  logic       overrun;
  logic [7:0] xfer_count;

  logic       out_valid4;
  logic [7:0] data_out4;
  logic       ack_tgl4;
  logic       overrun4;
  logic [3:0] xfer_count4;

  int n_cmp  = 0;
  int n_fail = 0;

  toggle_handshake_receiver #(.WIDTH(8), .SYNC_STAGES(SYNC), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_tgl(req_tgl), .data_in(data_in), .out_ready(out_ready),
    .out_valid(out_valid), .data_out(data_out), .ack_tgl(ack_tgl), .overrun(overrun),
    .xfer_count(xfer_count)
  );

  toggle_handshake_receiver #(.WIDTH(8), .SYNC_STAGES(SYNC), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .req_tgl(req_tgl), .data_in(data_in), .out_ready(out_ready),
    .out_valid(out_valid4), .data_out(data_out4), .ack_tgl(ack_tgl4), .overrun(overrun4),
    .xfer_count(xfer_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each flip becomes a queued arrival at a known edge number.
  typedef struct {
    int         at;
    logic [7:0] d;
  } flip_t;

  flip_t      q[$];
  int         cyc = 0;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ack;
  logic       m_ovr;
  int         m_cnt;

  always @(posedge clk or negedge reset) begin
    logic  ev;
    logic  hs;
    flip_t f;
    if (!reset) begin
      q.delete();
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_ack   <= 1'b0;
      m_ovr   <= 1'b0;
      m_cnt   <= 0;
    end else begin
      ev = (q.size() > 0) && (q[0].at == cyc + 1);
      hs = m_valid && out_ready;
      if (hs) begin
        m_ack <= ~m_ack;
        m_cnt <= m_cnt + 1;
      end
      if (ev) begin
        f = q.pop_front();
        if (!m_valid || hs) begin
          m_data  <= f.d;
          m_valid <= 1'b1;
        end else begin
          m_ovr <= 1'b1;
        end
      end else if (hs) begin
        m_valid <= 1'b0;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called at a negedge: present new data and flip the request.
  task automatic send(input logic [7:0] d);
    flip_t f;
    data_in = d;
    req_tgl = ~req_tgl;
    f.at = cyc + 1 + SYNC;
    f.d  = d;
    q.push_back(f);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    req_tgl = 1'b0;
    out_ready = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({out_valid, data_out, ack_tgl, overrun, xfer_count} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h a=%b o=%b c=%0d, want all 0",
               out_valid, data_out, ack_tgl, overrun, xfer_count);
    end
    n_cmp++;
    if ({out_valid4, ack_tgl4, overrun4, xfer_count4} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_state4: got v=%b a=%b o=%b c=%0d, want all 0",
               out_valid4, ack_tgl4, overrun4, xfer_count4);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(8'hA5);
    step(SYNC);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early: out_valid=%b before latency, want 0", out_valid);
    end
    step(1);
    n_cmp++;
    if (out_valid !== 1'b1 || data_out !== 8'hA5 || ack_tgl !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_deliver: v=%b d=%h a=%b, want v=1 d=a5 a=0", out_valid, data_out, ack_tgl);
    end
    step(1);
    n_cmp++;
    if (out_valid !== 1'b0 || ack_tgl !== 1'b1 || xfer_count !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_ack: v=%b a=%b c=%0d, want v=0 a=1 c=1", out_valid, ack_tgl, xfer_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic       a0;
    logic [7:0] c0;
    a0 = ack_tgl;
    c0 = xfer_count;
    out_ready = 1'b0;
    send(8'h3C);
    step(SYNC + 1);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || data_out !== 8'h3C || ack_tgl !== a0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: v=%b d=%h a=%b, want v=1 d=3c a=%b", i, out_valid, data_out, ack_tgl, a0);
      end
      step(1);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(2);
    n_cmp++;
    if (ack_tgl !== ~a0 || xfer_count !== c0 + 8'd1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: a=%b c=%0d v=%b, want a=%b c=%0d v=0", ack_tgl, xfer_count, out_valid, ~a0, c0 + 8'd1);
    end
  endtask

  task automatic test_overrun();
    logic a0;
    out_ready = 1'b0;
    send(8'h11);
    step(SYNC + 1);
    a0 = ack_tgl;
    send(8'h22);
    step(SYNC + 2);
    n_cmp++;
    if (overrun !== 1'b1 || data_out !== 8'h11 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set: o=%b d=%h v=%b, want o=1 d=11 v=1", overrun, data_out, out_valid);
    end
    out_ready = 1'b1;
    step(4);
    n_cmp++;
    if (ack_tgl !== ~a0 || out_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_release: a=%b v=%b o=%b, want a=%b v=0 o=1", ack_tgl, out_valid, overrun, ~a0);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_same_edge();
    logic       a0;
    logic [7:0] c0;
    do_reset();
    send(8'h44);
    step(SYNC + 1);
    a0 = ack_tgl;
    c0 = xfer_count;
    send(8'h55);
    step(SYNC);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || data_out !== 8'h55 || ack_tgl !== ~a0 ||
        xfer_count !== c0 + 8'd1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL same_edge: v=%b d=%h a=%b c=%0d o=%b, want v=1 d=55 a=%b c=%0d o=0",
               out_valid, data_out, ack_tgl, xfer_count, overrun, ~a0, c0 + 8'd1);
    end
    step(3);
    n_cmp++;
    if (out_valid !== 1'b1 || ack_tgl !== ~a0) begin
      n_fail++;
      $display("FAIL same_edge_hold: v=%b a=%b, want v=1 a=%b", out_valid, ack_tgl, ~a0);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(8'($urandom));
      step(SYNC + 3);
    end
    n_cmp++;
    if (xfer_count4 !== 4'd1 || ack_tgl4 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap4: c=%0d a=%b, want c=1 a=1", xfer_count4, ack_tgl4);
    end
    n_cmp++;
    if (xfer_count !== 8'd17 || ack_tgl !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap8: c=%0d a=%b, want c=17 a=1", xfer_count, ack_tgl);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int since;
    do_reset();
    since = 100;
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if (since >= SYNC + 2 && $urandom_range(0, 3) == 0) begin
        send(8'($urandom));
        since = 0;
      end else begin
        since++;
      end
      step(1);
      n_cmp++;
      if (out_valid !== m_valid || data_out !== m_data || ack_tgl !== m_ack ||
          overrun !== m_ovr || xfer_count !== m_cnt[7:0] || xfer_count4 !== m_cnt[3:0]) begin
        n_fail++;
        $display("FAIL rand[%0d]: v=%b d=%h a=%b o=%b c=%0d c4=%0d, want v=%b d=%h a=%b o=%b c=%0d c4=%0d",
                 i, out_valid, data_out, ack_tgl, overrun, xfer_count, xfer_count4,
                 m_valid, m_data, m_ack, m_ovr, m_cnt[7:0], m_cnt[3:0]);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_hold();
    do_reset();
    out_ready = 1'b0;
    send(8'h77);
    step(SYNC + 2);
    n_cmp++;
    if (out_valid !== 1'b1 || data_out !== 8'h77) begin
      n_fail++;
      $display("FAIL rst_hold_pre: v=%b d=%h, want v=1 d=77", out_valid, data_out);
    end
    #2;
    reset   = 1'b0;
    req_tgl = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, data_out, ack_tgl, overrun, xfer_count} !== 19'd0) begin
      n_fail++;
      $display("FAIL rst_async: v=%b d=%h a=%b o=%b c=%0d, want all 0",
               out_valid, data_out, ack_tgl, overrun, xfer_count);
    end
    step(2);
    reset = 1'b1;
    step(1);
    out_ready = 1'b1;
    send(8'h5A);
    step(SYNC + 1);
    n_cmp++;
    if (out_valid !== 1'b1 || data_out !== 8'h5A || ack_tgl !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_redeliver: v=%b d=%h a=%b, want v=1 d=5a a=0", out_valid, data_out, ack_tgl);
    end
    step(1);
    n_cmp++;
    if (ack_tgl !== 1'b1 || xfer_count !== 8'd1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_reack: a=%b c=%0d v=%b, want a=1 c=1 v=0", ack_tgl, xfer_count, out_valid);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    req_tgl   = 1'b0;
    data_in   = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_same_edge();
    test_wrap();
    test_random();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_handshake_receiver.md
Name: toggle_handshake_receiver

Overview:
- Receive end of the team's toggle-based clock-domain-crossing handshake.
- The sender encodes each transfer as a level flip on req_tgl, generated by a T-flop, and holds data_in stable alongside it.
- This block synchronises req_tgl, detects each flip, captures data_in and presents it on a valid/ready interface.
- It returns a flip on ack_tgl once the local consumer takes the word, closing the four-phase-free two-phase loop.

Parameters:
- WIDTH, 8, width of data_in / data_out
- SYNC_STAGES, 2, synchroniser flops on req_tgl; legal values >= 2
- CNT_W, 8, width of the transfer counter

Ports:
- clk  input  1  receive-domain clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_tgl  input  1  request toggle from the sender domain; asynchronous to clk
- data_in  input  WIDTH  bundled data from the sender; stable from before a req_tgl flip until the matching ack_tgl flip
- out_ready  input  1  consumer ready
- out_valid  output  1  data_out holds an unconsumed word
- data_out  output  WIDTH  captured word
- ack_tgl  output  1  acknowledge toggle back to the sender
- overrun  output  1  sticky error: a request arrived while the holding register was full
- xfer_count  output  CNT_W  number of words consumed, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, asynchronous):
  - Clear the synchroniser chain, req_seen, out_valid, data_out, ack_tgl, overrun and xfer_count to 0.
  - The FSM goes to IDLE.
  - The sender must also start with req_tgl=0.
- Synchroniser:
  - sync[0] <= req_tgl; sync[i] <= sync[i-1].
  - req_seen <= sync[SYNC_STAGES-1] on every clock.
  - event = sync[SYNC_STAGES-1] XOR req_seen (combinational, one-cycle pulse per flip).
- Latency:
  - A req_tgl flip first sampled at edge E0 raises out_valid at edge E0+SYNC_STAGES.
  - With the default SYNC_STAGES=2, that is edge E0+2.
  - data_out is loaded at that same edge.
- Handshake: the word is taken on any edge where out_valid=1 and out_ready=1. At that edge:
  - ack_tgl flips.
  - xfer_count increments, wrapping from 2^CNT_W-1 to 0.
- FSM:
  - IDLE (out_valid=0): on event, load data_out <= data_in and go to HOLD. With no event, stay in IDLE.
  - HOLD (out_valid=1), handshake and no event: go to IDLE; out_valid falls next cycle.
  - HOLD, handshake and event on the same edge: load the new data_in and stay in HOLD. out_valid stays 1, ack_tgl flips once, and the counter increments once.
  - HOLD, event without handshake: overrun <= 1. The new word is dropped and data_out keeps the old word. No extra ack is sent.
  - HOLD, no event and no handshake: hold all state. data_out must not change while out_valid=1.
- out_ready is ignored while out_valid=0; no ack and no count in that case.
- overrun stays set until reset; it has no other clear.
- Reset mid-operation: any pending word is discarded and no ack is issued for it. The sender re-synchronises by being reset with this block.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset release, then flip req_tgl 0->1 with data_in=8'hA5, out_ready=1 -> out_valid=1 with data_out=8'hA5 at the 2nd edge after sampling. One cycle later ack_tgl=1, xfer_count=1, out_valid=0.
- Back-pressure: out_ready=0, deliver 8'h3C -> out_valid and data_out=8'h3C hold for 10 cycles and ack_tgl stays 0. Raise out_ready -> exactly one ack flip and xfer_count+1.
- Overrun: with 8'h11 held and out_ready=0, flip req_tgl again with data_in=8'h22 -> overrun=1 and data_out stays 8'h11. Release out_ready -> one ack; overrun stays 1 until reset.
- Same-edge handshake and event, forced by aligning out_ready with a second flip -> data_out becomes the new word, out_valid stays 1, one ack flip, overrun=0.
- Wrap: CNT_W=4, 17 complete transfers -> xfer_count reads 1, and ack_tgl has flipped 17 times (final value 1).
- Assert reset while in HOLD with out_ready=0 -> all outputs 0 immediately, without waiting for a clock edge. After release, a new 0->1 flip delivers normally.
